// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan sequencer: FSM encoding, channel count
// and settle counter width.
package mux_scan_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;
endpackage

// File: rtl/mux4x1b.sv
// 4:1 one-bit multiplexer scanned by mux4_scan_capture.
module mux4x1b (
    input  logic [1:0] sl,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic       y
);
    always_comb begin
        y = in0;
        case (sl)
            2'd0: y = in0;
            2'd1: y = in1;
            2'd2: y = in2;
            2'd3: y = in3;
            default: y = in0;
        endcase
    end
endmodule

// File: rtl/settle_timer.sv
// Counts cycles while enabled; done flags the last settle cycle so the
// sequencer can move to SAMPLE on that edge.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/mux4_scan_capture.sv
// Steps the mux select through all channels, samples mux_out once per
// channel after a settle delay, and hands the 4-bit word over via valid/ack.
module mux4_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mux_out,
    output logic [SEL_W-1:0] sl,
    output logic             busy,
    output logic [NUM_CH-1:0] data,
    output logic             valid,
    input  logic             ack
);
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("mux4_scan_capture: SETTLE_CYCLES must be 1..15");
        end
    endgenerate

    logic [1:0] state;
    logic       tmr_clear;
    logic       tmr_en;
    logic       settle_done;

    // Counter only runs in SETTLE; every other state holds it at zero.
    assign tmr_en    = (state == SETTLE);
    assign tmr_clear = (state != SETTLE);

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .done   (settle_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sl    <= '0;
            busy  <= 1'b0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETTLE;
                        sl    <= '0;
                        data  <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        sl    <= '0;
                        data  <= '0;
                        busy  <= 1'b0;
                    end else if (settle_done) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state <= IDLE;
                        sl    <= '0;
                        data  <= '0;
                        busy  <= 1'b0;
                    end else begin
                        data[sl] <= mux_out;
                        // Last channel parks sl at 11 until the word is consumed.
                        if (sl == SEL_W'(NUM_CH - 1)) begin
                            state <= HOLD;
                            valid <= 1'b1;
                        end else begin
                            sl    <= sl + 1'b1;
                            state <= SETTLE;
                        end
                    end
                end
                HOLD: begin
                    if (ack || abort) begin
                        state <= IDLE;
                        sl    <= '0;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mux4_scan_capture.md
Name: mux4_scan_capture

Overview:
- Sequencer that sits around the 4:1 one-bit multiplexer (mux4x1b).
- Upstream role: it drives the mux select lines through 00, 01, 10, 11.
- Downstream role: it samples the mux output for each select value and assembles the four samples into a 4-bit word.
- On completion it presents the word with a valid/ack handshake to the next stage.

Parameters:
- SETTLE_CYCLES, default 1: cycles `sl` is held stable before each sample. Legal range is 1..15; values outside are an elaboration error.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- abort  input  1  cancels a scan in progress and returns to IDLE next edge.
- mux_out  input  1  output of the 4:1 mux being scanned.
- sl  output  2  select lines driven to the mux.
- busy  output  1  high in SETTLE, SAMPLE and HOLD.
- data  output  4  captured word; data[i] is the sample taken with sl == i.
- valid  output  1  data is complete and stable.
- ack  input  1  consumer accepts data; honoured only while valid = 1.

Behaviour:
- All outputs are registered.
- Reset, on a clk edge with reset = 1: state = IDLE, sl = 2'b00, busy = 0, data = 4'b0000, valid = 0, settle count = 0.
- Reset dominates every other input, including mid-scan and in HOLD.
- FSM states are IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - sl = 00, busy = 0, valid = 0.
  - start = 1 moves to SETTLE with sl = 00 and count = 0.
  - data is cleared to 0000 on that same edge.
- SETTLE:
  - count increments each cycle.
  - When count == SETTLE_CYCLES-1, next state is SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
  - sl holds its value throughout.
- SAMPLE (1 cycle), at the exit edge:
  - data[sl] <= mux_out.
  - If sl == 11: go to HOLD and set valid = 1; sl stays 11.
  - Otherwise: sl <= sl + 1, count <= 0, return to SETTLE.
- HOLD:
  - valid = 1, busy = 1; data and sl are frozen.
  - ack = 1 returns to IDLE; next cycle valid = 0, sl = 00, and data keeps the last word.
- Latency: valid rises 4*(SETTLE_CYCLES+1) edges after the edge that accepted start. For SETTLE_CYCLES = 1 that is 8 cycles.
- abort:
  - In SETTLE or SAMPLE: next state is IDLE, sl = 00, valid = 0, and the partial data is cleared to 0000.
  - In HOLD: abort acts like ack.
  - In IDLE: no effect.
- Simultaneous events:
  - start while busy is ignored; it is not queued.
  - start together with abort in IDLE: start wins.
  - ack together with start in HOLD: go to IDLE only; start must be re-asserted.
  - ack while valid = 0 is ignored.
- Only one mux_out sample is taken per channel, so glitches on mux_out during SETTLE have no effect.
- sl wraps only through IDLE; it never increments past 11.

Decomposition:
- Shared package mux_scan_pkg holds:
  - state encoding constants: IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, HOLD = 2'd3;
  - NUM_CH = 4 and SEL_W = 2;
  - CNT_W = 4, the settle counter width.
- One natural sub-module, settle_timer:
  - inputs: clk, reset, clear, enable;
  - output: done, asserted when count == SETTLE_CYCLES-1;
  - instantiated once.
- FSM, sl register and data register stay in the top module.
- The bench instantiates mux4x1b driven by `sl`, with mux_out connected to it.

Test Plan:
- Reset check: hold reset 2 cycles, then release -> sl = 00, busy = 0, valid = 0, data = 0000.
- Single scan:
  - Stimulus: SETTLE_CYCLES = 1, mux inputs {in3,in2,in1,in0} = 1,0,1,1; pulse start.
  - Required: sl steps 00 -> 01 -> 10 -> 11, each held 2 cycles; valid = 1 exactly 8 cycles after the start edge; data = 4'b1011.
  - Then ack -> valid = 0 next cycle and sl = 00.
- Settle length: SETTLE_CYCLES = 3, inputs 0,1,1,0 -> each sl value held 4 cycles; valid at cycle 16; data = 4'b0110.
- Abort mid-scan: abort asserted while sl = 10 -> next cycle IDLE, busy = 0, data = 0000, valid never rises.
- Handshake stall: withhold ack for 10 cycles in HOLD, toggling mux inputs and pulsing start -> data, sl and valid unchanged; ack then returns to IDLE without a new scan.
- Reset in HOLD: reset while valid = 1 -> next cycle valid = 0 and data = 0000; a subsequent start runs a clean full scan.
